chip8_mem_arbiter: RTL and testbench
====================================

Name: chip8_mem_arbiter

Overview:
- Shares the single-port 4 KB CHIP-8 RAM between three requesters: video scanout (VID), pixel processing unit (PPU) and CPU.
- One access per clock. VID has fixed top priority. PPU and CPU alternate round-robin.
- The PPU can lock out the CPU for the duration of a sprite read-modify-write.
- CPU writes into the interpreter region (font plus framebuffer) are blocked.

Parameters:
- ADDR_W, 12, address width.
- DATA_W, 8, data width.
- LOCK_TIMEOUT, 64, maximum consecutive cycles a PPU lock may be held.
- PROTECT_TOP, 12'h200, CPU writes to addresses below this value are dropped.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- vid_req  in  1  scanout read request (read-only).
- vid_addr  in  ADDR_W  scanout address.
- vid_gnt  out  1  scanout request accepted this cycle.
- vid_rvalid  out  1  mem_rdata valid for VID.
- ppu_req  in  1  PPU request.
- ppu_we  in  1  PPU write (0 = read).
- ppu_lock  in  1  keep bus reserved from CPU after this access.
- ppu_addr  in  ADDR_W  PPU address.
- ppu_wdata  in  DATA_W  PPU write data.
- ppu_gnt  out  1  PPU request accepted.
- ppu_rvalid  out  1  mem_rdata valid for PPU.
- cpu_req  in  1  CPU request.
- cpu_we  in  1  CPU write.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU request accepted.
- cpu_rvalid  out  1  mem_rdata valid for CPU.
- cpu_wr_fault  out  1  one-cycle pulse: CPU write dropped by protection.
- mem_rdata  out  DATA_W  shared read-data return (RAM data passed through).
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_re.
- locked  out  1  PPU lock active.
- lock_timeout  out  1  one-cycle pulse: lock forcibly released.

Behaviour:
- Grant logic
  - Grants are combinational from the current req inputs plus registered state.
  - At most one gnt is high per cycle.
  - The request is consumed in the cycle its gnt is high. The requester holds req/addr/we/wdata stable until it sees gnt.
  - ram_addr, ram_we, ram_re and ram_wdata are combinationally muxed from the winner. With no winner, all are 0.
- Priority
  - vid_req always wins.
  - Otherwise, when the bus is unlocked and both PPU and CPU request, the winner is the one not granted most recently (last_rr register).
  - After reset last_rr = CPU, so the PPU wins the first tie.
  - A single requester wins immediately.
  - last_rr updates only on PPU or CPU grants.
- Read return
  - rvalid for the granted requester is registered high exactly one cycle after a read grant (latency 1).
  - mem_rdata = ram_rdata.
  - Writes produce no rvalid.
- Lock state machine, states UNLOCKED and LOCKED
  - UNLOCKED -> LOCKED: PPU granted with ppu_lock = 1.
  - In LOCKED: cpu_gnt is forced to 0. VID still wins over the PPU. A 7-bit counter counts cycles spent in LOCKED.
  - LOCKED -> UNLOCKED when any of these occurs:
    - PPU granted with ppu_lock = 0 (this access completes normally), or
    - ppu_req = 0 and ppu_lock = 0 in the same cycle, or
    - the counter reaches LOCK_TIMEOUT - 1; lock_timeout pulses and the counter clears.
  - locked = (state == LOCKED).
- Protection
  - A CPU write with cpu_addr < PROTECT_TOP that wins arbitration is still granted, so the CPU does not stall.
  - ram_we stays 0 for it and cpu_wr_fault pulses that cycle (registered, visible the next cycle).
  - CPU reads of the region are allowed.
- Reset
  - All rvalid = 0, cpu_wr_fault = 0, lock_timeout = 0, state = UNLOCKED, lock counter = 0, last_rr = CPU.
  - Grants and ram_* outputs are 0 while reset is high.
  - Reset mid-lock or mid-read drops any pending rvalid.
- Boundaries
  - All three requesting: VID, then the round-robin winner next cycle.
  - Simultaneous lock release and CPU request: the CPU may win the following cycle, not the release cycle.
  - Addresses are not wrapped or checked beyond protection.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- When defined:
  - Adds outputs ppu_stall_cnt[15:0] and cpu_stall_cnt[15:0].
  - Each counts cycles where that requester had req = 1 and gnt = 0.
  - The counters saturate at 16'hFFFF and clear on reset or on a new input, stats_clr (1-cycle, synchronous).
- When undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Basic read/write: CPU writes 8'hA5 to 12'h300, then reads it back → cpu_gnt high both cycles; cpu_rvalid one cycle after the read grant with mem_rdata = 8'hA5.
- Arbitration: vid_req, ppu_req and cpu_req all held high for 4 cycles → grants in order VID, VID, VID, VID. Then with vid_req low: PPU, CPU, PPU.
- Lock: PPU reads 12'h100 with ppu_lock = 1, CPU requesting → cpu_gnt stays 0. PPU then writes 12'h100 with ppu_lock = 0 → lock released, CPU granted the next cycle.
- Timeout: PPU locks and then idles with ppu_lock = 1 for 70 cycles → lock_timeout pulses after 64 locked cycles; locked falls; CPU granted.
- Protection: CPU writes 8'hFF to 12'h050 → cpu_gnt = 1, ram_we = 0, cpu_wr_fault pulses; a later read of 12'h050 returns the original font byte.
- Reset mid-lock: assert reset while locked with a read outstanding → locked = 0 and rvalid = 0 the next cycle; the first tie after reset is granted to the PPU.

Source files
------------

// File: rtl/chip8_mem_arbiter.sv
// rtl/chip8_mem_arbiter.sv - VID/PPU/CPU arbiter for the single-port CHIP-8 RAM.
// Optional stall counters are compiled in with MEM_ARB_STATS_EN.
module chip8_mem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8,
    parameter int LOCK_TIMEOUT = 64,
    parameter int PROTECT_TOP  = 12'h200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    input  logic              ppu_req,
    input  logic              ppu_we,
    input  logic              ppu_lock,
    input  logic [ADDR_W-1:0] ppu_addr,
    input  logic [DATA_W-1:0] ppu_wdata,
    output logic              ppu_gnt,
    output logic              ppu_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic              cpu_wr_fault,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
`ifdef MEM_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       ppu_stall_cnt,
    output logic [15:0]       cpu_stall_cnt,
`endif
    output logic              locked,
    output logic              lock_timeout
);

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} lock_state_e;
    typedef enum logic {RR_PPU, RR_CPU} rr_owner_e;

    localparam logic [ADDR_W-1:0] PROT_ADDR = ADDR_W'(PROTECT_TOP);
    localparam logic [6:0]        LOCK_LAST = 7'(LOCK_TIMEOUT - 1);

    lock_state_e state_q, state_d;
    rr_owner_e   last_rr_q, last_rr_d;
    logic [6:0]  lock_cnt_q, lock_cnt_d;
    logic        lock_timeout_q, lock_timeout_d;
    logic        vid_rvalid_q, vid_rvalid_d;
    logic        ppu_rvalid_q, ppu_rvalid_d;
    logic        cpu_rvalid_q, cpu_rvalid_d;
    logic        cpu_wr_fault_q, cpu_wr_fault_d;
    logic        cpu_wr_blocked;

    assign locked         = (state_q == ST_LOCKED);
    assign cpu_wr_blocked = cpu_we && (cpu_addr < PROT_ADDR);

    // While locked the PPU wins any non-VID cycle; the CPU is shut out.
    always_comb begin
        vid_gnt = 1'b0;
        ppu_gnt = 1'b0;
        cpu_gnt = 1'b0;
        if (!reset) begin
            if (vid_req) begin
                vid_gnt = 1'b1;
            end else if (ppu_req && (locked || !cpu_req || last_rr_q == RR_CPU)) begin
                ppu_gnt = 1'b1;
            end else if (cpu_req && !locked) begin
                cpu_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        if (vid_gnt) begin
            ram_addr = vid_addr;
            ram_re   = 1'b1;
        end else if (ppu_gnt) begin
            ram_addr  = ppu_addr;
            ram_wdata = ppu_we ? ppu_wdata : '0;
            ram_we    = ppu_we;
            ram_re    = !ppu_we;
        end else if (cpu_gnt) begin
            // A blocked write is still granted so the CPU never stalls on it.
            ram_addr  = cpu_addr;
            ram_wdata = (cpu_we && !cpu_wr_blocked) ? cpu_wdata : '0;
            ram_we    = cpu_we && !cpu_wr_blocked;
            ram_re    = !cpu_we;
        end
    end

    always_comb begin
        state_d        = state_q;
        lock_cnt_d     = lock_cnt_q;
        lock_timeout_d = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                lock_cnt_d = '0;
                if (ppu_gnt && ppu_lock) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if ((ppu_gnt && !ppu_lock) || (!ppu_req && !ppu_lock)) begin
                    state_d    = ST_UNLOCKED;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d        = ST_UNLOCKED;
                    lock_cnt_d     = '0;
                    lock_timeout_d = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + 7'd1;
                end
            end
            default: begin
                state_d    = ST_UNLOCKED;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        last_rr_d = last_rr_q;
        if (ppu_gnt) begin
            last_rr_d = RR_PPU;
        end else if (cpu_gnt) begin
            last_rr_d = RR_CPU;
        end
        vid_rvalid_d   = vid_gnt;
        ppu_rvalid_d   = ppu_gnt && !ppu_we;
        cpu_rvalid_d   = cpu_gnt && !cpu_we;
        cpu_wr_fault_d = cpu_gnt && cpu_wr_blocked;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_UNLOCKED;
            lock_cnt_q     <= '0;
            lock_timeout_q <= 1'b0;
            last_rr_q      <= RR_CPU;
            vid_rvalid_q   <= 1'b0;
            ppu_rvalid_q   <= 1'b0;
            cpu_rvalid_q   <= 1'b0;
            cpu_wr_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            lock_cnt_q     <= lock_cnt_d;
            lock_timeout_q <= lock_timeout_d;
            last_rr_q      <= last_rr_d;
            vid_rvalid_q   <= vid_rvalid_d;
            ppu_rvalid_q   <= ppu_rvalid_d;
            cpu_rvalid_q   <= cpu_rvalid_d;
            cpu_wr_fault_q <= cpu_wr_fault_d;
        end
    end

    assign vid_rvalid   = vid_rvalid_q;
    assign ppu_rvalid   = ppu_rvalid_q;
    assign cpu_rvalid   = cpu_rvalid_q;
    assign cpu_wr_fault = cpu_wr_fault_q;
    assign lock_timeout = lock_timeout_q;
    assign mem_rdata    = ram_rdata;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] ppu_stall_q, ppu_stall_d;
    logic [15:0] cpu_stall_q, cpu_stall_d;

    // Saturating counts of cycles spent waiting with req high.
    always_comb begin
        ppu_stall_d = ppu_stall_q;
        cpu_stall_d = cpu_stall_q;
        if (ppu_req && !ppu_gnt && ppu_stall_q != 16'hFFFF) begin
            ppu_stall_d = ppu_stall_q + 16'd1;
        end
        if (cpu_req && !cpu_gnt && cpu_stall_q != 16'hFFFF) begin
            cpu_stall_d = cpu_stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            ppu_stall_q <= '0;
            cpu_stall_q <= '0;
        end else begin
            ppu_stall_q <= ppu_stall_d;
            cpu_stall_q <= cpu_stall_d;
        end
    end

    assign ppu_stall_cnt = ppu_stall_q;
    assign cpu_stall_cnt = cpu_stall_q;
`endif

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb/tb_chip8_mem_arbiter.sv - directed self-checking bench for chip8_mem_arbiter.
// RAM model preloads mem[a] = a[7:0] ^ 8'h5A.
module tb_chip8_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        vid_req;
    logic [11:0] vid_addr;
    logic        vid_gnt, vid_rvalid;
    logic        ppu_req, ppu_we, ppu_lock;
    logic [11:0] ppu_addr;
    logic [7:0]  ppu_wdata;
    logic        ppu_gnt, ppu_rvalid;
    logic        cpu_req, cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt, cpu_rvalid, cpu_wr_fault;
    logic [7:0]  mem_rdata;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we, ram_re;
    logic [7:0]  ram_rdata;
    logic        locked, lock_timeout;
`ifdef MEM_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] ppu_stall_cnt, cpu_stall_cnt;
`endif

    int checks;
    int failures;

    logic [7:0] mem [0:4095];
    logic       mem_init;

    chip8_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid),
        .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_lock(ppu_lock), .ppu_addr(ppu_addr),
        .ppu_wdata(ppu_wdata), .ppu_gnt(ppu_gnt), .ppu_rvalid(ppu_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_wr_fault(cpu_wr_fault),
        .mem_rdata(mem_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata),
`ifdef MEM_ARB_STATS_EN
        .stats_clr(stats_clr), .ppu_stall_cnt(ppu_stall_cnt), .cpu_stall_cnt(cpu_stall_cnt),
`endif
        .locked(locked), .lock_timeout(lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            if (ram_re) ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vid_req = 0; vid_addr = '0;
        ppu_req = 0; ppu_we = 0; ppu_lock = 0; ppu_addr = '0; ppu_wdata = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1; mem_init = 1;
        idle_inputs();
        tick();
        mem_init = 0;
        vid_req = 1; ppu_req = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 12'h300;
        #1;
        checks++; if ({vid_gnt, ppu_gnt, cpu_gnt} !== 3'b000) begin failures++; $display("FAIL reset_gnt: got %b want 000", {vid_gnt, ppu_gnt, cpu_gnt}); end
        checks++; if ({ram_we, ram_re, ram_addr} !== 14'h0) begin failures++; $display("FAIL reset_ram: got we=%b re=%b addr=%h want 0", ram_we, ram_re, ram_addr); end
        tick();
        checks++; if ({locked, lock_timeout, vid_rvalid, ppu_rvalid, cpu_rvalid, cpu_wr_fault} !== 6'b0) begin
            failures++; $display("FAIL reset_regs: got %b want 000000", {locked, lock_timeout, vid_rvalid, ppu_rvalid, cpu_rvalid, cpu_wr_fault});
        end
        idle_inputs();
        reset = 0;
        tick();
    endtask

    task automatic test_basic_rw();
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h300; cpu_wdata = 8'hA5;
        #1;
        checks++; if ({cpu_gnt, ram_we, ram_addr, ram_wdata} !== {2'b11, 12'h300, 8'hA5}) begin
            failures++; $display("FAIL rw_write: got gnt=%b we=%b addr=%h wd=%h want 1 1 300 a5", cpu_gnt, ram_we, ram_addr, ram_wdata);
        end
        tick();
        checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL rw_write_rvalid: got %b want 0", cpu_rvalid); end
        cpu_we = 0;
        #1;
        checks++; if ({cpu_gnt, ram_re} !== 2'b11) begin failures++; $display("FAIL rw_read_gnt: got %b want 11", {cpu_gnt, ram_re}); end
        tick();
        cpu_req = 0;
        checks++; if ({cpu_rvalid, mem_rdata} !== {1'b1, 8'hA5}) begin failures++; $display("FAIL rw_readback: got v=%b d=%h want 1 a5", cpu_rvalid, mem_rdata); end
        tick();
        checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL rw_rvalid_pulse: got %b want 0", cpu_rvalid); end
    endtask

    task automatic test_arbitration();
        logic [2:0]  exp_g [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b010};
        logic [11:0] exp_a [7] = '{12'h010, 12'h010, 12'h010, 12'h010, 12'h120, 12'h300, 12'h120};
        ppu_req = 1; ppu_addr = 12'h120;
        cpu_req = 1; cpu_addr = 12'h300;
        vid_addr = 12'h010;
        for (int c = 0; c < 7; c++) begin
            vid_req = (c < 4);
            #1;
            checks++; if ({vid_gnt, ppu_gnt, cpu_gnt, ram_addr} !== {exp_g[c], exp_a[c]}) begin
                failures++; $display("FAIL arb_cycle%0d: got gnt=%b addr=%h want %b %h", c, {vid_gnt, ppu_gnt, cpu_gnt}, ram_addr, exp_g[c], exp_a[c]);
            end
            tick();
            if (c == 0) begin
                checks++; if ({vid_rvalid, mem_rdata} !== {1'b1, 8'h4A}) begin failures++; $display("FAIL arb_vid_rdata: got v=%b d=%h want 1 4a", vid_rvalid, mem_rdata); end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_lock();
        ppu_req = 1; ppu_lock = 1; ppu_addr = 12'h100;
        #1;
        checks++; if (ppu_gnt !== 1'b1) begin failures++; $display("FAIL lock_grant: got %b want 1", ppu_gnt); end
        tick();
        ppu_req = 0;
        cpu_req = 1; cpu_addr = 12'h300;
        checks++; if ({locked, ppu_rvalid, mem_rdata} !== {2'b11, 8'h5A}) begin
            failures++; $display("FAIL lock_entry: got l=%b v=%b d=%h want 1 1 5a", locked, ppu_rvalid, mem_rdata);
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if ({cpu_gnt, locked} !== 2'b01) begin failures++; $display("FAIL lock_cpu_blocked%0d: got gnt=%b l=%b want 0 1", c, cpu_gnt, locked); end
            tick();
        end
        ppu_req = 1; ppu_we = 1; ppu_lock = 0; ppu_wdata = 8'hC3;
        #1;
        checks++; if ({ppu_gnt, cpu_gnt, ram_we} !== 3'b101) begin failures++; $display("FAIL lock_release_cycle: got %b want 101", {ppu_gnt, cpu_gnt, ram_we}); end
        tick();
        ppu_req = 0; ppu_we = 0;
        #1;
        checks++; if ({locked, cpu_gnt, ppu_rvalid} !== 3'b010) begin failures++; $display("FAIL lock_after_release: got %b want 010", {locked, cpu_gnt, ppu_rvalid}); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        int pulse_at = -1;
        int pulses = 0;
        int locked_cycles = 0;
        int cpu_leak = 0;
        logic cpu_at_release = 1'b0;
        ppu_req = 1; ppu_lock = 1; ppu_addr = 12'h140;
        #1;
        tick();
        ppu_req = 0;
        cpu_req = 1; cpu_addr = 12'h310;
        for (int s = 1; s <= 70; s++) begin
            #1;
            if (lock_timeout) begin pulses++; if (pulse_at < 0) pulse_at = s; end
            if (locked) locked_cycles++;
            if (locked && cpu_gnt) cpu_leak++;
            if (s == 65) cpu_at_release = cpu_gnt;
            tick();
        end
        checks++; if (pulse_at != 65) begin failures++; $display("FAIL timeout_when: got %0d want 65", pulse_at); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL timeout_pulses: got %0d want 1", pulses); end
        checks++; if (locked_cycles != 64) begin failures++; $display("FAIL timeout_locked_cycles: got %0d want 64", locked_cycles); end
        checks++; if (cpu_leak != 0) begin failures++; $display("FAIL timeout_cpu_leak: got %0d want 0", cpu_leak); end
        checks++; if (cpu_at_release !== 1'b1) begin failures++; $display("FAIL timeout_cpu_gnt: got %b want 1", cpu_at_release); end
        idle_inputs();
        tick();
    endtask

    task automatic test_protection();
        logic [11:0] addrs [3] = '{12'h050, 12'h1FF, 12'h200};
        logic [1:0]  exp   [3] = '{2'b01, 2'b01, 2'b10};
        cpu_req = 1; cpu_we = 1; cpu_wdata = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            cpu_addr = addrs[i];
            #1;
            checks++; if ({cpu_gnt, ram_we} !== {1'b1, exp[i][1]}) begin
                failures++; $display("FAIL prot_we_%h: got gnt=%b we=%b want 1 %b", addrs[i], cpu_gnt, ram_we, exp[i][1]);
            end
            tick();
            checks++; if (cpu_wr_fault !== exp[i][0]) begin failures++; $display("FAIL prot_fault_%h: got %b want %b", addrs[i], cpu_wr_fault, exp[i][0]); end
        end
        cpu_we = 0; cpu_addr = 12'h050;
        #1;
        tick();
        cpu_req = 0;
        checks++; if ({cpu_rvalid, mem_rdata, cpu_wr_fault} !== {1'b1, 8'h0A, 1'b0}) begin
            failures++; $display("FAIL prot_readback: got v=%b d=%h f=%b want 1 0a 0", cpu_rvalid, mem_rdata, cpu_wr_fault);
        end
        tick();
    endtask

    task automatic test_reset_mid_lock();
        ppu_req = 1; ppu_lock = 1; ppu_addr = 12'h120;
        #1;
        tick();
        checks++; if ({locked, ppu_rvalid} !== 2'b11) begin failures++; $display("FAIL rml_setup: got %b want 11", {locked, ppu_rvalid}); end
        reset = 1; cpu_req = 1; cpu_addr = 12'h300;
        #1;
        checks++; if ({ppu_gnt, cpu_gnt, ram_re} !== 3'b000) begin failures++; $display("FAIL rml_gnt_in_reset: got %b want 000", {ppu_gnt, cpu_gnt, ram_re}); end
        tick();
        checks++; if ({locked, ppu_rvalid, cpu_rvalid} !== 3'b000) begin failures++; $display("FAIL rml_cleared: got %b want 000", {locked, ppu_rvalid, cpu_rvalid}); end
        reset = 0; ppu_lock = 0;
        #1;
        checks++; if ({ppu_gnt, cpu_gnt} !== 2'b10) begin failures++; $display("FAIL rml_first_tie: got %b want 10", {ppu_gnt, cpu_gnt}); end
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
`ifdef MEM_ARB_STATS_EN
        stats_clr = 0;
`endif
        test_reset();
        test_basic_rw();
        test_arbitration();
        test_lock();
        test_timeout();
        test_protection();
        test_reset_mid_lock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
